cp_mem_arbiter: RTL and testbench
=================================

// Module: cp_mem_arbiter
// PURPOSE
// - Shares the command processor memory controller port between two requesters:
//   A (host program loader) and B (command processor sequencer).
// - Valid/ready transfer per requester; round-robin arbitration; optional
//   burst lock. Command stage is registered towards the memory controller.
// - Read data is returned with a tagged rvalid to the requester that issued it.
// PARAMETERS
// - ADDR_W        14   memory controller address width
// - DATA_W        32   data width
// - LOCK_TIMEOUT  256  idle cycles before a held lock is broken (CPARB_LOCK_TIMEOUT_EN only)
// PORTS
// - clk              in   1       clock
// - rst              in   1       asynchronous, active-high reset
// - a_req/b_req      in   1       request valid; fields held stable until gnt
// - a_lock/b_lock    in   1       keep ownership after this transfer
// - a_we/b_we        in   1       1 = write, 0 = read
// - a_prog_sel/b_*   in   2       target VSCPU (01 CM, 10 CT, 11 agent 1)
// - a_addr/b_addr    in   ADDR_W  word address
// - a_wdata/b_wdata  in   DATA_W  write data
// - a_gnt/b_gnt      out  1       combinational; req & gnt at posedge = transfer
// - a_rvalid/b_rvalid out 1       read data valid for that requester
// - rdata            out  DATA_W  shared read data (= cp_mem_ctrl_out)
// - program_sel      out  2       to memory controller
// - cp_mem_ctrl_we   out  1       to memory controller
// - cp_mem_ctrl_addr out  ADDR_W  to memory controller
// - cp_mem_ctrl_in   out  DATA_W  to memory controller
// - cp_mem_ctrl_out  in   DATA_W  from memory controller
// - lock_err         out  1       one-cycle pulse: lock forcibly broken
// BEHAVIOUR
// - Reset: program_sel=00, cp_mem_ctrl_we=0, addr/in=0, gnt=0, rvalid=0,
//   lock_err=0, lock state NONE, rr pointer = A preferred.
// - Idle command (no transfer last cycle): program_sel=00, we=0; the memory
//   controller then selects no SRAM and blocks main memory writes.
// - Lock state: NONE / LOCK_A / LOCK_B.
//   NONE: a single requester is granted; on conflict, grant goes to the one not
//   granted last (rr pointer updated on every transfer).
//   LOCK_x: only x may be granted; the other gnt=0.
//   NONE->LOCK_x on a transfer from x with x_lock=1. LOCK_x->NONE on a transfer
//   from x with x_lock=0, or x_req=0 and x_lock=0 in any cycle.
// - Transfer in cycle N: at the end of N, register {prog_sel,we,addr,wdata}
//   onto the controller outputs, driven during N+1; the SRAM samples at the end of N+1.
// - Read tag pipeline: 2-stage shift register of {valid, owner}. A read
//   transferred in N gives x_rvalid=1 in N+2 with rdata valid. Writes give no rvalid.
// - Throughput: one transfer per cycle total; back-to-back reads return in order.
// - A transfer with prog_sel=00 is accepted. It has no memory effect, and a
//   read returns rdata=0 with rvalid.
// - gnt never depends on rvalid; a requester may issue while its reads are in flight.
// - Reset mid-operation: in-flight reads are discarded (no rvalid), lock is
//   cleared and the outputs return to idle immediately.
// CONFIGURATION
// - CPARB_LOCK_TIMEOUT_EN defined: a counter counts consecutive cycles in
//   LOCK_x with no transfer from x. At LOCK_TIMEOUT the lock is forced to NONE,
//   lock_err pulses for 1 cycle and the rr pointer points at the other requester.
//   The counter clears on any transfer and on leaving LOCK_x.
// - Not defined: locks persist indefinitely; lock_err is tied to 0.
// TESTING
// - Write A only: prog_sel=01, addr=0x0005, wdata=0xDEADBEEF -> a_gnt same
//   cycle; controller outputs show we=1, addr=0x0005 the next cycle.
// - Read A at N (prog_sel=10, addr=0x0203), controller returns 0x12345678 ->
//   a_rvalid=1 and rdata=0x12345678 exactly in N+2; b_rvalid stays 0.
// - Both req every cycle, no lock, 6 cycles -> grants alternate A,B,A,B,A,B;
//   rvalid tags match the owners.
// - A locks for 4 writes (lock=1,1,1,0) while B requests -> b_gnt=0 for 4
//   transfers, then B is granted the following cycle.
// - CPARB_LOCK_TIMEOUT_EN, LOCK_TIMEOUT=8: A locks, then goes idle with lock=1
//   while B requests -> lock_err after 8 cycles, b_gnt the next cycle.
// - Assert rst while 2 reads are in flight -> no rvalid; program_sel=00 and
//   we=0 immediately; arbitration restarts with A preferred.

Source files
------------

// File: rtl/cp_mem_arbiter.sv
// Two-requester round-robin arbiter with burst lock in front of the CP memory controller.
// Optional lock watchdog: define CPARB_LOCK_TIMEOUT_EN.
module cp_mem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_lock,
  input  logic              a_we,
  input  logic [1:0]        a_prog_sel,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_lock,
  input  logic              b_we,
  input  logic [1:0]        b_prog_sel,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        program_sel,
  output logic              cp_mem_ctrl_we,
  output logic [ADDR_W-1:0] cp_mem_ctrl_addr,
  output logic [DATA_W-1:0] cp_mem_ctrl_in,
  input  logic [DATA_W-1:0] cp_mem_ctrl_out,
  output logic              lock_err
);

  typedef struct packed {
    logic [1:0]        prog_sel;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {L_NONE, L_A, L_B} lock_t;

`ifdef CPARB_LOCK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);

  cmd_t       cmd_a, cmd_b, cmd_sel;
  logic [1:0] req, gnt, xfer;
  lock_t      lock_q, lock_nom, lock_d;
  logic       rr_q, rr_d;          // 1: B preferred on conflict
  logic       held_idle, brk;
  logic [TO_W-1:0] to_cnt;
  logic [1:0] vld_pipe, own_pipe, null_pipe;

  assign cmd_a   = '{prog_sel: a_prog_sel, we: a_we, addr: a_addr, wdata: a_wdata};
  assign cmd_b   = '{prog_sel: b_prog_sel, we: b_we, addr: b_addr, wdata: b_wdata};
  assign req     = {b_req, a_req};
  assign xfer    = req & gnt;
  assign cmd_sel = xfer[1] ? cmd_b : cmd_a;
  assign a_gnt   = gnt[0];
  assign b_gnt   = gnt[1];

  always_comb begin
    gnt = '0;
    if (!rst) begin
      case (lock_q)
        L_NONE: begin
          if (req[0] && (!req[1] || !rr_q)) gnt[0] = 1'b1;
          else if (req[1])                  gnt[1] = 1'b1;
        end
        L_A:     gnt[0] = req[0];
        L_B:     gnt[1] = req[1];
        default: gnt = '0;
      endcase
    end
  end

  always_comb begin
    lock_nom = lock_q;
    case (lock_q)
      L_NONE: begin
        if (xfer[0] && a_lock)      lock_nom = L_A;
        else if (xfer[1] && b_lock) lock_nom = L_B;
      end
      L_A: if ((xfer[0] && !a_lock) || (!a_req && !a_lock)) lock_nom = L_NONE;
      L_B: if ((xfer[1] && !b_lock) || (!b_req && !b_lock)) lock_nom = L_NONE;
      default: lock_nom = L_NONE;
    endcase
  end

  // Watchdog: owner holds the lock but moves nothing for LOCK_TIMEOUT cycles.
  assign held_idle = ((lock_q == L_A) && !xfer[0]) || ((lock_q == L_B) && !xfer[1]);
  assign brk       = TO_EN && held_idle && (lock_nom != L_NONE) &&
                     (to_cnt == TO_W'(LOCK_TIMEOUT - 1));
  assign lock_err  = brk;

  always_comb begin
    lock_d = lock_nom;
    rr_d   = (|xfer) ? xfer[0] : rr_q;
    if (brk) begin
      lock_d = L_NONE;
      rr_d   = (lock_q == L_A);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= L_NONE;
      rr_q   <= 1'b0;
      to_cnt <= '0;
    end else begin
      lock_q <= lock_d;
      rr_q   <= rr_d;
      if (TO_EN && held_idle && (lock_nom != L_NONE) && !brk) to_cnt <= to_cnt + 1'b1;
      else                                                    to_cnt <= '0;
    end
  end

  // Command stage: a transfer in N is presented to the controller in N+1, idle otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      program_sel      <= '0;
      cp_mem_ctrl_we   <= 1'b0;
      cp_mem_ctrl_addr <= '0;
      cp_mem_ctrl_in   <= '0;
    end else if (|xfer) begin
      program_sel      <= cmd_sel.prog_sel;
      cp_mem_ctrl_we   <= cmd_sel.we;
      cp_mem_ctrl_addr <= cmd_sel.addr;
      cp_mem_ctrl_in   <= cmd_sel.wdata;
    end else begin
      program_sel      <= '0;
      cp_mem_ctrl_we   <= 1'b0;
      cp_mem_ctrl_addr <= '0;
      cp_mem_ctrl_in   <= '0;
    end
  end

  // Read tags: {valid, owner, no-target} travel two stages to meet the SRAM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      own_pipe  <= '0;
      null_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[0],  (|xfer) && !cmd_sel.we};
      own_pipe  <= {own_pipe[0],  xfer[1]};
      null_pipe <= {null_pipe[0], cmd_sel.prog_sel == 2'b00};
    end
  end

  assign a_rvalid = vld_pipe[1] && !own_pipe[1];
  assign b_rvalid = vld_pipe[1] &&  own_pipe[1];
  assign rdata    = (vld_pipe[1] && null_pipe[1]) ? '0 : cp_mem_ctrl_out;

endmodule

// File: tb/tb_cp_mem_arbiter.sv
// Directed self-checking bench for cp_mem_arbiter with a one-cycle-latency SRAM model.
module tb_cp_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        a_req, a_lock, a_we, b_req, b_lock, b_we;
  logic [1:0]  a_prog_sel, b_prog_sel, program_sel;
  logic [13:0] a_addr, b_addr, cp_mem_ctrl_addr;
  logic [31:0] a_wdata, b_wdata, rdata, cp_mem_ctrl_in, cp_mem_ctrl_out;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, cp_mem_ctrl_we, lock_err;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  cp_mem_arbiter #(.ADDR_W(14), .DATA_W(32), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_prog_sel(a_prog_sel),
    .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_prog_sel(b_prog_sel),
    .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rdata(rdata), .program_sel(program_sel), .cp_mem_ctrl_we(cp_mem_ctrl_we),
    .cp_mem_ctrl_addr(cp_mem_ctrl_addr), .cp_mem_ctrl_in(cp_mem_ctrl_in),
    .cp_mem_ctrl_out(cp_mem_ctrl_out), .lock_err(lock_err)
  );

  // SRAM model: samples the command at the end of its cycle; never returns zero itself.
  function automatic logic [31:0] mem_val(input logic [1:0] ps, input logic [13:0] ad);
    if (ps == 2'b10 && ad == 14'h0203) return 32'h12345678;
    return {ps, 2'b01, 14'h0, ad};
  endfunction
  always @(posedge clk) cp_mem_ctrl_out <= mem_val(program_sel, cp_mem_ctrl_addr);

  task automatic tick; @(posedge clk); #1; endtask
  task automatic samp; @(negedge clk); endtask

  task automatic idle;
    a_req = 0; a_lock = 0; a_we = 0; a_prog_sel = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_lock = 0; b_we = 0; b_prog_sel = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic set_a(input logic rq, lk, we, input logic [1:0] ps,
                       input logic [13:0] ad, input logic [31:0] wd);
    a_req = rq; a_lock = lk; a_we = we; a_prog_sel = ps; a_addr = ad; a_wdata = wd;
  endtask

  task automatic set_b(input logic rq, lk, we, input logic [1:0] ps,
                       input logic [13:0] ad, input logic [31:0] wd);
    b_req = rq; b_lock = lk; b_we = we; b_prog_sel = ps; b_addr = ad; b_wdata = wd;
  endtask

  task automatic do_reset;
    rst = 1; idle; tick; tick; rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; set_a(1, 0, 1, 2'b01, 14'h5, 32'h1); set_b(1, 0, 0, 2'b11, 14'h6, 32'h2);
    tick; samp;
    checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL rst_a_gnt got=%0h exp=0", a_gnt); end
    checks++; if (b_gnt !== 1'b0) begin errors++; $display("FAIL rst_b_gnt got=%0h exp=0", b_gnt); end
    checks++; if (program_sel !== 2'b00) begin errors++; $display("FAIL rst_psel got=%0h exp=0", program_sel); end
    checks++; if (cp_mem_ctrl_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%0h exp=0", cp_mem_ctrl_we); end
    checks++; if (cp_mem_ctrl_addr !== 14'h0 || cp_mem_ctrl_in !== 32'h0) begin errors++; $display("FAIL rst_addr_in got=%0h/%0h exp=0/0", cp_mem_ctrl_addr, cp_mem_ctrl_in); end
    checks++; if ({a_rvalid, b_rvalid, lock_err} !== 3'b000) begin errors++; $display("FAIL rst_rvalid_err got=%0b exp=000", {a_rvalid, b_rvalid, lock_err}); end
  endtask

  task automatic test_write_a;
    do_reset; set_a(1, 0, 1, 2'b01, 14'h0005, 32'hDEADBEEF); samp;
    checks++; if ({a_gnt, b_gnt} !== 2'b10) begin errors++; $display("FAIL wr_gnt got=%0b exp=10", {a_gnt, b_gnt}); end
    tick; idle; samp;
    checks++; if (program_sel !== 2'b01 || cp_mem_ctrl_we !== 1'b1) begin errors++; $display("FAIL wr_cmd got=%0h/%0h exp=1/1", program_sel, cp_mem_ctrl_we); end
    checks++; if (cp_mem_ctrl_addr !== 14'h0005 || cp_mem_ctrl_in !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data got=%0h/%0h exp=5/deadbeef", cp_mem_ctrl_addr, cp_mem_ctrl_in); end
    tick; samp;
    checks++; if (program_sel !== 2'b00 || cp_mem_ctrl_we !== 1'b0 || a_rvalid !== 1'b0) begin errors++; $display("FAIL wr_idle got=%0h/%0h/%0h exp=0/0/0", program_sel, cp_mem_ctrl_we, a_rvalid); end
  endtask

  task automatic test_read_a;
    do_reset; set_a(1, 0, 0, 2'b10, 14'h0203, 32'h0); samp;
    checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got=%0h exp=1", a_gnt); end
    tick; idle; samp;
    checks++; if (program_sel !== 2'b10 || cp_mem_ctrl_we !== 1'b0 || cp_mem_ctrl_addr !== 14'h0203) begin errors++; $display("FAIL rd_cmd got=%0h/%0h/%0h exp=2/0/203", program_sel, cp_mem_ctrl_we, cp_mem_ctrl_addr); end
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early got=%0h exp=0", a_rvalid); end
    tick; samp;
    checks++; if ({a_rvalid, b_rvalid} !== 2'b10) begin errors++; $display("FAIL rd_rvalid got=%0b exp=10", {a_rvalid, b_rvalid}); end
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL rd_data got=%0h exp=12345678", rdata); end
    tick; samp;
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rd_late got=%0h exp=0", a_rvalid); end
  endtask

  task automatic test_round_robin;
    logic ea, ra;
    do_reset;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick;
      if (i < 6) begin
        set_a(1, 0, 0, 2'b01, 14'h0001, 32'h0); set_b(1, 0, 0, 2'b11, 14'h0010, 32'h0);
      end else idle;
      samp;
      ea = (i % 2 == 0);
      if (i < 6) begin
        checks++; if ({a_gnt, b_gnt} !== {ea, !ea}) begin errors++; $display("FAIL rr_gnt[%0d] got=%0b exp=%0b", i, {a_gnt, b_gnt}, {ea, !ea}); end
      end
      if (i >= 2) begin
        ra = ((i - 2) % 2 == 0);
        checks++; if ({a_rvalid, b_rvalid} !== {ra, !ra}) begin errors++; $display("FAIL rr_tag[%0d] got=%0b exp=%0b", i, {a_rvalid, b_rvalid}, {ra, !ra}); end
        checks++; if (rdata !== (ra ? 32'h50000001 : 32'hD0000010)) begin errors++; $display("FAIL rr_data[%0d] got=%0h exp=%0h", i, rdata, ra ? 32'h50000001 : 32'hD0000010); end
      end
    end
  endtask

  task automatic test_lock;
    logic ea;
    do_reset; set_b(1, 0, 0, 2'b11, 14'h0010, 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick;
      set_a(1, i < 3, 1, 2'b01, 14'(i), 32'(i));
      samp;
      ea = (i < 4);
      checks++; if ({a_gnt, b_gnt} !== {ea, !ea}) begin errors++; $display("FAIL lock_gnt[%0d] got=%0b exp=%0b", i, {a_gnt, b_gnt}, {ea, !ea}); end
      checks++; if (lock_err !== 1'b0) begin errors++; $display("FAIL lock_err[%0d] got=%0h exp=0", i, lock_err); end
    end
  endtask

  task automatic test_lock_hold;
    do_reset; set_a(1, 1, 1, 2'b01, 14'h0, 32'h0); set_b(1, 0, 0, 2'b11, 14'h0010, 32'h0); samp;
    checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL hold_first got=%0h exp=1", a_gnt); end
`ifdef CPARB_LOCK_TIMEOUT_EN
    for (int i = 1; i <= 9; i++) begin
      tick; set_a(0, 1, 0, 2'b00, 14'h0, 32'h0); samp;
      checks++; if (lock_err !== (i == 8)) begin errors++; $display("FAIL to_err[%0d] got=%0h exp=%0h", i, lock_err, i == 8); end
      checks++; if (b_gnt !== (i == 9)) begin errors++; $display("FAIL to_bgnt[%0d] got=%0h exp=%0h", i, b_gnt, i == 9); end
    end
`else
    for (int i = 1; i <= 20; i++) begin
      tick; set_a(0, 1, 0, 2'b00, 14'h0, 32'h0); samp;
      checks++; if (b_gnt !== 1'b0 || lock_err !== 1'b0) begin errors++; $display("FAIL hold[%0d] got=%0b exp=00", i, {b_gnt, lock_err}); end
    end
    tick; a_lock = 0; samp;
    checks++; if (b_gnt !== 1'b0) begin errors++; $display("FAIL hold_release got=%0h exp=0", b_gnt); end
    tick; samp;
    checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL hold_after got=%0h exp=1", b_gnt); end
`endif
  endtask

  task automatic test_null_sel;
    do_reset; set_a(1, 0, 0, 2'b00, 14'h0007, 32'h0); samp;
    checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL null_gnt got=%0h exp=1", a_gnt); end
    tick; idle; samp;
    checks++; if (program_sel !== 2'b00 || cp_mem_ctrl_we !== 1'b0) begin errors++; $display("FAIL null_cmd got=%0h/%0h exp=0/0", program_sel, cp_mem_ctrl_we); end
    tick; samp;
    checks++; if (a_rvalid !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL null_rd got=%0h/%0h exp=1/0", a_rvalid, rdata); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick;
      if (i < 3) set_a(1, 0, 0, 2'b01, 14'(i + 1), 32'h0); else idle;
      samp;
      if (i < 3) begin
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d] got=%0h exp=1", i, a_gnt); end
      end
      if (i >= 2) begin
        checks++; if (a_rvalid !== 1'b1 || rdata !== 32'h50000000 + 32'(i - 1)) begin errors++; $display("FAIL b2b_rd[%0d] got=%0h/%0h exp=1/%0h", i, a_rvalid, rdata, 32'h50000000 + 32'(i - 1)); end
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset; set_a(1, 0, 0, 2'b01, 14'h0001, 32'h0); samp;
    tick; idle; set_b(1, 0, 0, 2'b11, 14'h0010, 32'h0); samp;
    checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL mid_bgnt got=%0h exp=1", b_gnt); end
    tick; idle; rst = 1; samp;
    checks++; if (program_sel !== 2'b00 || cp_mem_ctrl_we !== 1'b0) begin errors++; $display("FAIL mid_idle got=%0h/%0h exp=0/0", program_sel, cp_mem_ctrl_we); end
    checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin errors++; $display("FAIL mid_rv0 got=%0b exp=00", {a_rvalid, b_rvalid}); end
    tick; samp;
    checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin errors++; $display("FAIL mid_rv1 got=%0b exp=00", {a_rvalid, b_rvalid}); end
    tick; rst = 0;
    set_a(1, 0, 0, 2'b01, 14'h0001, 32'h0); set_b(1, 0, 0, 2'b11, 14'h0010, 32'h0); samp;
    checks++; if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== 4'b1000) begin errors++; $display("FAIL mid_restart got=%0b exp=1000", {a_gnt, b_gnt, a_rvalid, b_rvalid}); end
  endtask

  initial begin
    idle;
    test_reset;
    test_write_a;
    test_read_a;
    test_round_robin;
    test_lock;
    test_lock_hold;
    test_null_sel;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
